// File: rtl/serdes_pkg.sv
// Shared definitions for the serial/parallel conversion blocks.
package serdes_pkg;

  // Bit-order encodings carried on cfg_msb_first-style configuration inputs.
  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  // Width needed to hold a bit count from 0 up to and including max_width.
  function automatic int clog2_cnt(input int max_width);
    return $clog2(max_width + 1);
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// One-word output holding register for assembled words.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, out_data/out_width stay stable until that transfer.
// The producer may only assert load when the register is empty or is being
// drained on the same edge; a load then replaces the drained word and
// out_valid stays high.
module deser_out_reg
  import serdes_pkg::*;
#(
  parameter int MAX_WIDTH = 32,
  parameter int CNT_BITS  = clog2_cnt(MAX_WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 load,
  input  logic [MAX_WIDTH-1:0] load_data,
  input  logic [CNT_BITS-1:0]  load_width,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [MAX_WIDTH-1:0] out_data,
  output logic [CNT_BITS-1:0]  out_width
);

  // Load / drain / load-while-draining; flush discards the held word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_width <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_width <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_width <= load_width;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: LANES bits per beat into words of run-time
// width, with selectable bit order, back-pressure, flush and a sticky
// configuration-error flag.
//
// Handshake: input beats transfer on a rising edge where in_valid && in_ready;
// output words transfer where out_valid && out_ready. in_ready only drops for
// the beat that would complete a word while the previous word is still held
// and not being taken this cycle, so partial beats keep flowing under stall.
module serial_deserializer
  import serdes_pkg::*;
#(
  parameter int MAX_WIDTH = 32,
  parameter int LANES     = 1,
  parameter int CNT_BITS  = clog2_cnt(MAX_WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [CNT_BITS-1:0]  cfg_width,
  input  logic                 cfg_msb_first,
  input  logic                 in_valid,
  input  logic [LANES-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] out_data,
  output logic [CNT_BITS-1:0]  out_width,
  output logic                 cfg_err
);

  localparam logic [CNT_BITS-1:0] MAX_W     = CNT_BITS'(MAX_WIDTH);
  localparam logic [CNT_BITS-1:0] LANE_STEP = CNT_BITS'(LANES);

  logic                 running;
  logic [CNT_BITS-1:0]  cnt;
  logic [CNT_BITS-1:0]  w_lat;
  logic                 msb_lat;
  logic [MAX_WIDTH-1:0] partial;

  logic                 cfg_illegal;
  logic [CNT_BITS-1:0]  cfg_w_safe;
  logic                 word_start;
  logic [CNT_BITS-1:0]  w_eff;
  logic                 msb_eff;
  logic                 last_beat;
  logic                 accept;
  logic                 complete;
  logic [MAX_WIDTH-1:0] partial_next;
  logic [CNT_BITS-1:0]  pos;

  // Sanitise the requested width; illegal widths fall back to MAX_WIDTH.
  always_comb begin
    cfg_illegal = (cfg_width == '0) || (cfg_width > MAX_W) ||
                  ((cfg_width % LANE_STEP) != '0);
    cfg_w_safe  = cfg_illegal ? MAX_W : cfg_width;
  end

  // At word start the live configuration applies to the first beat; later
  // beats use the latched copy so mid-word changes have no effect.
  always_comb begin
    word_start = (cnt == '0);
    w_eff      = word_start ? cfg_w_safe : w_lat;
    msb_eff    = word_start ? cfg_msb_first : msb_lat;
    last_beat  = ((cnt + LANE_STEP) == w_eff);
    in_ready   = running && !(out_valid && !out_ready && last_beat);
    accept     = in_valid && in_ready && !flush;
    complete   = accept && last_beat;
  end

  // Place each lane bit of the current beat into its word position.
  always_comb begin
    partial_next = partial;
    pos          = '0;
    for (int k = 0; k < LANES; k++) begin
      if (msb_eff == LSB_FIRST) begin
        pos = cnt + CNT_BITS'(k);
      end else begin
        pos = w_eff - CNT_BITS'(1) - cnt - CNT_BITS'(k);
      end
      partial_next = partial_next | (MAX_WIDTH'(in_data[k]) << pos);
    end
  end

  // Bit counter, partial word, config latch and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      cnt     <= '0;
      w_lat   <= '0;
      msb_lat <= 1'b0;
      partial <= '0;
      cfg_err <= 1'b0;
    end else begin
      running <= 1'b1;
      if (flush) begin
        cnt     <= '0;
        partial <= '0;
      end else if (accept) begin
        if (word_start) begin
          w_lat   <= cfg_w_safe;
          msb_lat <= cfg_msb_first;
          if (cfg_illegal) begin
            cfg_err <= 1'b1;
          end
        end
        if (complete) begin
          cnt     <= '0;
          partial <= '0;
        end else begin
          cnt     <= cnt + LANE_STEP;
          partial <= partial_next;
        end
      end
    end
  end

  deser_out_reg #(
    .MAX_WIDTH (MAX_WIDTH),
    .CNT_BITS  (CNT_BITS)
  ) u_out_reg (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .load       (complete),
    .load_data  (partial_next),
    .load_width (w_eff),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_width  (out_width)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: one LANES=1 and one LANES=4 instance,
// directed scenarios followed by randomised traffic, all checked against a
// word-level reference model and an expected-word queue per instance.
module tb_serial_deserializer;

  localparam int MW = 32;
  localparam int CB = 6;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- stimulus signals (index 0: LANES=1, index 1: LANES=4)
  logic          flush_s     [2];
  logic          msb_s       [2];
  logic          in_valid_s  [2];
  logic          out_ready_s [2];
  logic [CB-1:0] width_s     [2];
  logic [3:0]    data_s      [2];

  logic          a_in_ready, a_out_valid, a_cfg_err;
  logic [MW-1:0] a_out_data;
  logic [CB-1:0] a_out_width;
  logic          b_in_ready, b_out_valid, b_cfg_err;
  logic [MW-1:0] b_out_data;
  logic [CB-1:0] b_out_width;

  serial_deserializer #(.MAX_WIDTH(MW), .LANES(1)) dut_a (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush_s[0]),
    .cfg_width     (width_s[0]),
    .cfg_msb_first (msb_s[0]),
    .in_valid      (in_valid_s[0]),
    .in_data       (data_s[0][0:0]),
    .in_ready      (a_in_ready),
    .out_valid     (a_out_valid),
    .out_ready     (out_ready_s[0]),
    .out_data      (a_out_data),
    .out_width     (a_out_width),
    .cfg_err       (a_cfg_err)
  );

  serial_deserializer #(.MAX_WIDTH(MW), .LANES(4)) dut_b (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush_s[1]),
    .cfg_width     (width_s[1]),
    .cfg_msb_first (msb_s[1]),
    .in_valid      (in_valid_s[1]),
    .in_data       (data_s[1]),
    .in_ready      (b_in_ready),
    .out_valid     (b_out_valid),
    .out_ready     (out_ready_s[1]),
    .out_data      (b_out_data),
    .out_width     (b_out_width),
    .cfg_err       (b_cfg_err)
  );

  // ---------------- reference model state ----------------
  int checks   = 0;
  int failures = 0;

  int            lanes    [2] = '{1, 4};
  int            cur_n    [2];
  int            cur_w    [2];
  bit            cur_msb  [2];
  logic [MW-1:0] cur_word [2];
  bit            err_m    [2];
  bit            acc      [2];
  logic [MW-1:0] last_word  [2];
  logic [CB-1:0] last_width [2];
  bit            started;

  logic [CB+MW-1:0] exp_q_a[$];
  logic [CB+MW-1:0] exp_q_b[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(int w, int l);
    return (w != 0) && (w <= MW) && ((w % l) == 0);
  endfunction

  function automatic int eff_w(int w, int l);
    return is_legal(w, l) ? w : MW;
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  task automatic q_push(int i, logic [CB+MW-1:0] v);
    if (i == 0) exp_q_a.push_back(v);
    else        exp_q_b.push_back(v);
  endtask

  task automatic q_pop(int i, output logic [CB+MW-1:0] v);
    if (i == 0) v = exp_q_a.pop_front();
    else        v = exp_q_b.pop_front();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cur_n[i] = 0; cur_w[i] = 0; cur_msb[i] = 0; cur_word[i] = '0; err_m[i] = 0;
    end
    exp_q_a.delete();
    exp_q_b.delete();
    started = 0;
  endtask

  // ---------------- driver: one clock cycle for both instances ----------
  task automatic tick();
    logic          rdy [2];
    logic          ov  [2];
    logic          ce  [2];
    logic [MW-1:0] od  [2];
    logic [CB-1:0] ow  [2];
    #3;
    rdy[0] = a_in_ready;  rdy[1] = b_in_ready;
    ov[0]  = a_out_valid; ov[1]  = b_out_valid;
    ce[0]  = a_cfg_err;   ce[1]  = b_cfg_err;
    od[0]  = a_out_data;  od[1]  = b_out_data;
    ow[0]  = a_out_width; ow[1]  = b_out_width;
    for (int i = 0; i < 2; i++) begin
      int               wn;
      bit               comp;
      bit               pend;
      bit               exp_rdy;
      logic [CB+MW-1:0] e;
      wn      = (cur_n[i] == 0) ? eff_w(int'(width_s[i]), lanes[i]) : cur_w[i];
      comp    = (cur_n[i] + lanes[i] == wn);
      pend    = (q_size(i) > 0);
      exp_rdy = started && !(pend && !out_ready_s[i] && comp);
      check($sformatf("in_ready[%0d]", i), 64'(rdy[i]), 64'(exp_rdy));
      check($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(pend));
      check($sformatf("cfg_err[%0d]", i), 64'(ce[i]), 64'(err_m[i]));
      acc[i] = in_valid_s[i] && exp_rdy && !flush_s[i];
      if (flush_s[i]) begin
        cur_n[i] = 0;
        if (i == 0) exp_q_a.delete();
        else        exp_q_b.delete();
      end else begin
        if (pend && out_ready_s[i]) begin
          q_pop(i, e);
          check($sformatf("out_data[%0d]", i), 64'(od[i]), 64'(e[MW-1:0]));
          check($sformatf("out_width[%0d]", i), 64'(ow[i]), 64'(e[CB+MW-1:MW]));
          last_word[i]  = od[i];
          last_width[i] = ow[i];
        end
        if (acc[i]) begin
          if (cur_n[i] == 0) begin
            cur_w[i]    = wn;
            cur_msb[i]  = msb_s[i];
            cur_word[i] = '0;
            if (!is_legal(int'(width_s[i]), lanes[i])) err_m[i] = 1;
          end
          for (int k = 0; k < lanes[i]; k++) begin
            int idx;
            idx = cur_n[i] + k;
            if (cur_msb[i]) idx = cur_w[i] - 1 - idx;
            cur_word[i] = cur_word[i] | (MW'(data_s[i][k]) << idx);
          end
          cur_n[i] += lanes[i];
          if (cur_n[i] == cur_w[i]) begin
            q_push(i, {CB'(cur_w[i]), cur_word[i]});
            cur_n[i] = 0;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    if (reset) started = 1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(int i, logic [3:0] d);
    in_valid_s[i] = 1'b1;
    data_s[i]     = d;
    acc[i]        = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (acc[i]) break;
    end
    check($sformatf("send_accept[%0d]", i), 64'(acc[i]), 64'd1);
    in_valid_s[i] = 1'b0;
  endtask

  // Send nbeats beats taken from bits, earliest beat in the low bits.
  task automatic send_seq(int i, logic [63:0] bits, int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      send(i, 4'(bits >> (b * lanes[i])));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      flush_s[i] = 0; msb_s[i] = 0; in_valid_s[i] = 0; out_ready_s[i] = 1;
      width_s[i] = 6'd8; data_s[i] = '0;
      last_word[i] = '0; last_width[i] = '0;
    end
    model_reset();

    // Reset state
    #1;
    check("rst_in_ready", 64'(a_in_ready), 64'd0);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_data", 64'(a_out_data), 64'd0);
    check("rst_out_width", 64'(a_out_width), 64'd0);
    check("rst_cfg_err", 64'(a_cfg_err), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    tick();

    // LSB-first 8 bits -> 0x4D, single-cycle out_valid
    send_seq(0, 64'b01001101, 8);
    tick();
    check("lsb8_data", 64'(last_word[0]), 64'h4D);
    check("lsb8_width", 64'(last_width[0]), 64'd8);
    tick();

    // MSB-first same bits -> 0xB2
    msb_s[0] = 1;
    send_seq(0, 64'b01001101, 8);
    tick();
    check("msb8_data", 64'(last_word[0]), 64'hB2);

    // MSB-first width 4, bits 1,1,0,0 -> 0xC
    width_s[0] = 6'd4;
    send_seq(0, 64'b0011, 4);
    tick();
    check("msb4_data", 64'(last_word[0]), 64'hC);
    check("msb4_width", 64'(last_width[0]), 64'd4);

    // LANES=4, width 16, width change after beat 2 ignored
    width_s[1] = 6'd16; msb_s[1] = 0;
    send(1, 4'h1);
    send(1, 4'h2);
    width_s[1] = 6'd8;
    send(1, 4'h3);
    send(1, 4'h4);
    tick();
    check("l4_data", 64'(last_word[1]), 64'h4321);
    check("l4_width", 64'(last_width[1]), 64'd16);

    // Back-pressure: 0xA5 held, 7 partial beats flow, 8th stalls
    width_s[0] = 6'd8; msb_s[0] = 0; out_ready_s[0] = 0;
    send_seq(0, 64'hA5, 8);
    tick();
    send_seq(0, 64'h3C, 7);
    in_valid_s[0] = 1; data_s[0] = 4'(1'b0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("stall_hold", 64'(acc[0]), 64'd0);
    end
    out_ready_s[0] = 1;
    tick();
    check("stall_release_acc", 64'(acc[0]), 64'd1);
    check("stall_drain_word", 64'(last_word[0]), 64'hA5);
    in_valid_s[0] = 0;
    tick();
    check("stall_next_word", 64'(last_word[0]), 64'h3C);

    // Illegal width 0 -> MAX_WIDTH word, sticky cfg_err
    width_s[0] = 6'd0;
    send_seq(0, 64'(32'hDEAD_BEEF), 32);
    tick();
    check("illegal_width", 64'(last_width[0]), 64'd32);
    check("illegal_word", 64'(last_word[0]), 64'hDEAD_BEEF);
    check("illegal_err", 64'(a_cfg_err), 64'd1);

    // Flush after 3 beats, then a clean word
    width_s[0] = 6'd8;
    send_seq(0, 64'b111, 3);
    flush_s[0] = 1; in_valid_s[0] = 1; data_s[0] = 4'h1;
    tick();
    flush_s[0] = 0; in_valid_s[0] = 0;
    send_seq(0, 64'h96, 8);
    tick();
    check("flush_word", 64'(last_word[0]), 64'h96);
    check("flush_err_sticky", 64'(a_cfg_err), 64'd1);

    // Reset mid-word with a pending output
    out_ready_s[0] = 0;
    send_seq(0, 64'h5A, 8);
    tick();
    send_seq(0, 64'b10110, 5);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 64'(a_in_ready), 64'd0);
    check("midrst_out_valid", 64'(a_out_valid), 64'd0);
    check("midrst_out_data", 64'(a_out_data), 64'd0);
    check("midrst_out_width", 64'(a_out_width), 64'd0);
    check("midrst_cfg_err", 64'(a_cfg_err), 64'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready_s[0] = 1;
    check("rel_in_ready", 64'(a_in_ready), 64'd0);
    tick();
    send_seq(0, 64'h71, 8);
    tick();
    check("post_rst_word", 64'(last_word[0]), 64'h71);

    // Randomised traffic, config churn, back-pressure and occasional flush
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 700; c++) begin
        in_valid_s[i]  = ($urandom_range(0, 3) != 0);
        data_s[i]      = 4'($urandom);
        out_ready_s[i] = ($urandom_range(0, 2) != 0);
        flush_s[i]     = ($urandom_range(0, 59) == 0);
        msb_s[i]       = 1'($urandom);
        if ($urandom_range(0, 15) == 0) width_s[i] = 6'($urandom_range(0, 63));
        else if (i == 0)                width_s[i] = 6'($urandom_range(1, 12));
        else                            width_s[i] = 6'($urandom_range(1, 6) * 4);
        tick();
      end
      in_valid_s[i] = 0; flush_s[i] = 0; out_ready_s[i] = 1;
      tick();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Generalised serial-to-parallel converter. Accepts LANES bits per beat on a valid/ready stream and assembles words of run-time width cfg_width (1..MAX_WIDTH bits). Completed words go out through a one-word output register with valid/ready handshake.
- Supports LSB-first and MSB-first bit order, back-pressure without data loss, synchronous flush and a sticky configuration-error flag.
- Sits between bit-serial front ends (pin samplers, shift links) and word-wide consumers.

Parameters:
- MAX_WIDTH, 32, maximum assembled word width in bits; range 2..64.
- LANES, 1, serial bits accepted per beat; must divide MAX_WIDTH; values 1, 2, 4 or 8.
- CNT_BITS, $clog2(MAX_WIDTH+1), width of cfg_width and of the internal bit counter.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- flush, input, 1, synchronous clear of the partial word and the output register.
- cfg_width, input, CNT_BITS, word width in bits; sampled at word start.
- cfg_msb_first, input, 1, bit order: 1 = MSB first, 0 = LSB first; sampled at word start.
- in_valid, input, 1, in_data is valid this cycle.
- in_data, input, LANES, serial bits; in_data[0] is the earliest bit in time.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- out_valid, output, 1, out_data holds a completed word.
- out_ready, input, 1, consumer accepts the word when out_valid && out_ready.
- out_data, output, MAX_WIDTH, assembled word; bits at or above the word width are 0.
- out_width, output, CNT_BITS, width that out_data was assembled with.
- cfg_err, output, 1, sticky; set when an illegal cfg_width is sampled.

Behaviour:
- Reset (reset == 0, asynchronous): in_ready=0, out_valid=0, out_data=0, out_width=0, cfg_err=0. Partial register, bit counter and latched config are cleared.
- First clock edge with reset high: in_ready becomes 1. No beat is accepted on that edge.
- Word start (bit counter == 0): latch cfg_width and cfg_msb_first into w_lat and msb_lat.
- Illegal cfg_width: 0, > MAX_WIDTH, or not a multiple of LANES. The block uses MAX_WIDTH instead and sets cfg_err. cfg_err clears only on reset.
- Accepted beat: each bit in_data[k] is written to position p = cnt+k (LSB-first) or w_lat-1-(cnt+k) (MSB-first). Then cnt increments by LANES.
- Word completion: the beat that brings cnt+LANES == w_lat. The full word (including this beat) goes to out_data and out_width=w_lat on the same edge, out_valid=1 from the next cycle, cnt=0, and the partial register clears. Latency from last-beat acceptance to out_valid is 1 cycle.
- Output register: holds its value while out_valid && !out_ready. It clears out_valid on a handshake unless a new word completes on the same edge; in that case it loads the new word and out_valid stays 1.
- Back-pressure: in_ready = !(out_valid && !out_ready && (cnt+LANES == w_lat)). Partial beats are still accepted while the output is stalled; only the completing beat is held off. in_ready is combinational from out_ready.
- flush (synchronous, priority over all datapath updates): cnt=0, partial word=0, out_valid=0. Any beat presented in the same cycle is dropped. cfg_err is unaffected.
- Reset asserted mid-word or with out_valid=1: the partial word and pending output are discarded.
- cfg_width changes mid-word: ignored until the next word start.
- Counter wraps only at completion. cnt never exceeds w_lat.

Decomposition:
- Shared package serdes_pkg holds the function clog2_cnt(MAX_WIDTH) and the localparams for the LSB_FIRST/MSB_FIRST encodings, so the future parallel_to_serial uses the same encodings.
- One natural sub-module, deser_out_reg: the one-word valid/ready output holding register with its load/drain/simultaneous logic. The top level contains the counter, bit placement, config latch and error logic.

Test Plan:
- LANES=1, cfg_width=8, LSB-first, bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=1 -> out_data=0x4D, out_width=8, out_valid high for exactly one cycle, 1 cycle after the 8th beat.
- Same 8 bits with cfg_msb_first=1 -> out_data=0xB2. Then cfg_width=4 with bits 1,1,0,0 -> out_data=0xC, upper bits 0.
- LANES=4, cfg_width=16, beats 0x1,0x2,0x3,0x4, LSB-first -> out_data=0x4321. Toggling cfg_width to 8 after beat 2 has no effect on this word.
- out_ready=0 while out_valid=1 holding 0xA5: the 7 partial beats of the next word are accepted and the 8th sees in_ready=0. Raise out_ready -> 0xA5 drains, the 8th beat is accepted on that same edge, next out_data is correct, and no beat is lost or duplicated.
- cfg_width=0 at word start -> cfg_err=1 and the word completes after MAX_WIDTH bits. flush asserted after 3 beats -> cnt restarts; the following 8 beats produce a correct word and cfg_err stays 1.
- Assert reset after 5 of 8 bits with out_valid=1 -> all outputs 0 immediately. On release, in_ready=1 after one edge and the next 8 bits produce a clean word.
